// File: rtl/hnoc_rr_arbiter.sv
// Round-robin arbiter that merges NumIn valid/ready flit streams into one
// registered output stage. Arbitration is combinational from a rotating
// pointer. The winning flit is captured into the output register whenever
// that register is empty or is draining in the same cycle.
module hnoc_rr_arbiter #(
  parameter int NumIn      = 4,
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 3,
  parameter int TotalWidth = DataWidth + AddrWidth
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NumIn*TotalWidth-1:0] i_data,
  input  logic [NumIn-1:0]            i_data_valid,
  output logic [NumIn-1:0]            o_data_ready,
  output logic [TotalWidth-1:0]       o_data,
  output logic                        o_data_valid,
  input  logic                        i_data_ready,
  output logic [$clog2(NumIn)-1:0]    o_grant,
  output logic [31:0]                 o_flit_count
);

  localparam int GW = $clog2(NumIn);

  logic [TotalWidth-1:0] flit_arr [NumIn];

  logic [GW-1:0]         ptr_reg;
  logic [GW-1:0]         ptr_next;
  logic [TotalWidth-1:0] data_reg;
  logic                  valid_reg;
  logic [GW-1:0]         grant_reg;
  logic [31:0]           count_reg;
  logic [31:0]           count_next;

  logic                  win_found;
  logic [GW-1:0]         win_idx;
  logic                  load_en;
  logic                  in_xfer;

  // Unpack the flat input bus into one flit per port.
  genvar gi;
  generate
    for (gi = 0; gi < NumIn; gi++) begin : g_unpack
      assign flit_arr[gi] = i_data[gi*TotalWidth +: TotalWidth];
    end
  endgenerate

  // Search upward from the pointer (mod NumIn); the first valid port wins.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 0; off < NumIn; off++) begin
      cand = (int'(ptr_reg) + off) % NumIn;
      if (!win_found && i_data_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  // The output register can take a new flit when it is empty or draining now.
  assign load_en    = !valid_reg || i_data_ready;
  assign in_xfer    = win_found && load_en && !i_reset;
  assign ptr_next   = (win_idx == GW'(NumIn - 1)) ? '0 : win_idx + GW'(1);
  assign count_next = count_reg + 32'd1;

  // Only the winner sees ready, and only when its flit will actually be taken.
  generate
    for (gi = 0; gi < NumIn; gi++) begin : g_ready
      assign o_data_ready[gi] = in_xfer && (win_idx == GW'(gi));
    end
  endgenerate

  // Output stage, pointer and flit counter; everything holds while stalled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      grant_reg <= '0;
      count_reg <= '0;
    end else if (load_en) begin
      if (win_found) begin
        data_reg  <= flit_arr[win_idx];
        valid_reg <= 1'b1;
        grant_reg <= win_idx;
        ptr_reg   <= ptr_next;
        count_reg <= count_next;
      end else begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign o_data       = data_reg;
  assign o_data_valid = valid_reg;
  assign o_grant      = grant_reg;
  assign o_flit_count = count_reg;

endmodule

// File: tb/tb_hnoc_rr_arbiter.sv
// Scoreboard bench for hnoc_rr_arbiter: the stimulus pushes the hand-derived
// expected flit for every accepted transfer, and an independent monitor pops
// and compares whenever the output handshake completes.
module tb_hnoc_rr_arbiter;

  localparam int NumIn = 4;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int TW    = DW + AW;

  typedef struct packed {
    logic [TW-1:0] flit;
    logic [1:0]    port;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NumIn*TW-1:0]   din;
  logic [NumIn-1:0]      vld;
  logic [NumIn-1:0]      ordy;
  logic [TW-1:0]         dout;
  logic                  ovld;
  logic                  irdy;
  logic [1:0]            grant;
  logic [31:0]           cnt;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] seq      = 8'h00;
  logic [TW-1:0] held;

  always #5 clk = ~clk;

  hnoc_rr_arbiter #(
    .NumIn(NumIn), .DataWidth(DW), .AddrWidth(AW), .TotalWidth(TW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_data       (din),
    .i_data_valid (vld),
    .o_data_ready (ordy),
    .o_data       (dout),
    .o_data_valid (ovld),
    .i_data_ready (irdy),
    .o_grant      (grant),
    .o_flit_count (cnt)
  );

  // Flit tag: address = port, then port, then the step sequence number.
  function automatic logic [TW-1:0] flit_of(input int k, input logic [7:0] s);
    return {3'(k), 8'(k), 16'h0000, s};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One input cycle: drive after the edge, record expected acceptance,
  // then check the combinational ready on the falling edge.
  task automatic step(input logic r, input logic [3:0] v, input logic rd,
                      input logic [3:0] exp_rdy);
    @(posedge clk);
    #1;
    rst  = r;
    vld  = v;
    irdy = rd;
    for (int k = 0; k < NumIn; k++) begin
      din[k*TW +: TW] = flit_of(k, seq);
      if (exp_rdy[k]) sb_q.push_back('{flit: flit_of(k, seq), port: 2'(k)});
    end
    seq = seq + 8'd1;
    @(negedge clk);
    check("o_data_ready", 64'(ordy), 64'(exp_rdy));
    $display("in  rst=%b vld=%b rdy=%b o_data_ready=%b exp=%b", r, v, rd, ordy, exp_rdy);
  endtask

  // Output monitor: every completed output handshake consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ovld === 1'b1 && irdy === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", dout);
      end else begin
        e = sb_q.pop_front();
        check("out_flit", 64'(dout), 64'(e.flit));
        check("out_grant", 64'(grant), 64'(e.port));
        $display("out flit=%h grant=%0d exp_flit=%h exp_grant=%0d", dout, grant, e.flit, e.port);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    vld  = '0;
    irdy = 1'b0;
    din  = '0;

    // Reset: no ready even with every port valid; registers cleared.
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    check("rst_valid", 64'(ovld), 64'd0);
    check("rst_data", 64'(dout), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_count", 64'(cnt), 64'd0);

    // Port 2 alone, five back-to-back flits 0x10..0x14 (ptr 0 -> 3).
    seq = 8'h10;
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0100, 1'b1, 4'b0100);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("count_after_port2", 64'(cnt), 64'd5);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("idle_valid_low", 64'(ovld), 64'd0);

    // Pointer wrap: ptr 3 grants port 3, then wraps to port 1 (ptr -> 2).
    step(1'b0, 4'b1010, 1'b1, 4'b1000);
    step(1'b0, 4'b1010, 1'b1, 4'b0010);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);

    // Move ptr to 1 via port 0, then port 1 drops before it is served.
    step(1'b0, 4'b0001, 1'b1, 4'b0001);
    step(1'b0, 4'b0111, 1'b0, 4'b0000);
    step(1'b0, 4'b0101, 1'b1, 4'b0100);
    step(1'b0, 4'b0101, 1'b1, 4'b0001);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);

    // Stall: port 1 flit held for 3 cycles while ports 0 and 3 wait.
    held = flit_of(1, seq);
    step(1'b0, 4'b0010, 1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1001, 1'b0, 4'b0000);
      check("stall_data", 64'(dout), 64'(held));
      check("stall_grant", 64'(grant), 64'd1);
      check("stall_valid", 64'(ovld), 64'd1);
    end
    step(1'b0, 4'b1001, 1'b1, 4'b1000);
    step(1'b0, 4'b1001, 1'b1, 4'b0001);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);

    // Reset pulse mid-stream, then full round-robin over all four ports.
    step(1'b0, 4'b1111, 1'b1, 4'b0010);
    step(1'b0, 4'b1111, 1'b1, 4'b0100);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    step(1'b0, 4'b1111, 1'b1, 4'b0001);
    check("post_rst_valid", 64'(ovld), 64'd0);
    check("post_rst_count", 64'(cnt), 64'd0);
    step(1'b0, 4'b1111, 1'b1, 4'b0010);
    step(1'b0, 4'b1111, 1'b1, 4'b0100);
    step(1'b0, 4'b1111, 1'b1, 4'b1000);
    step(1'b0, 4'b1111, 1'b1, 4'b0001);
    step(1'b0, 4'b1111, 1'b1, 4'b0010);
    step(1'b0, 4'b1111, 1'b1, 4'b0100);
    step(1'b0, 4'b1111, 1'b1, 4'b1000);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("count_after_rr", 64'(cnt), 64'd8);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("drain_valid_low", 64'(ovld), 64'd0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hnoc_rr_arbiter.md
# hnoc_rr_arbiter

Round-robin arbiter that shares one HNoC flit output port among `NumIn` requesting input ports. Each input is a valid/ready flit stream carrying `{addr, data}`. The block registers the winning flit into a single output stage. Sits in front of a switch output or a PE ejection port and gives fair, full-throughput access with one cycle of latency.

## Interface
- `NumIn`, 4, number of requesting input ports (2..8).
- `DataWidth`, 32, payload width.
- `AddrWidth`, 3, destination address width.
- `TotalWidth`, `DataWidth+AddrWidth`, flit width. Address occupies the MSBs; the block never inspects it.

Ports:
- `i_clk`  in  1  single clock; all logic on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_data`  in  `NumIn*TotalWidth`  input flits; port k at bits `[k*TotalWidth +: TotalWidth]`.
- `i_data_valid`  in  `NumIn`  per-port flit valid.
- `o_data_ready`  out  `NumIn`  per-port accept; at most one bit high.
- `o_data`  out  `TotalWidth`  registered output flit.
- `o_data_valid`  out  1  registered output valid.
- `i_data_ready`  in  1  downstream accept.
- `o_grant`  out  `$clog2(NumIn)`  index of the port whose flit is in the output register.
- `o_flit_count`  out  32  total flits accepted since reset.

## Operation
- Transfer on the input side: `i_data_valid[k] && o_data_ready[k]`. Transfer on the output side: `o_data_valid && i_data_ready`.
- `load_en = !o_data_valid || i_data_ready`. The output register may accept a new flit only when `load_en` is high.
- Arbitration is combinational each cycle.
  - Search `i_data_valid` starting at pointer `ptr` and moving upward modulo `NumIn`.
  - The first set bit is the winner `w`.
  - `o_data_ready[w] = load_en && !i_reset`. All other bits are 0.
  - With no valid inputs, `o_data_ready` is all 0.
- On an input transfer:
  - `o_data <= i_data[w]`, `o_data_valid <= 1`, `o_grant <= w`.
  - `ptr <= (w+1) mod NumIn`.
  - `o_flit_count <= o_flit_count + 1`.
- On `load_en` with no winner: `o_data_valid <= 0`. `o_data` and `o_grant` hold their last values.
- When `load_en` is low (output stalled): `o_data`, `o_data_valid`, `o_grant` and `ptr` all hold.
- `ptr` advances only on an input transfer. Idle cycles never move it.
- Winner selection does not depend on `o_data_ready`; `o_data_ready` depends on `i_data_valid` and `i_data_ready`. Upstream ports must not make `i_data_valid` depend on `o_data_ready`.
- A requester may drop `i_data_valid` before it is granted. The arbiter simply skips it; no state is retained.
- `o_flit_count` wraps from `0xFFFFFFFF` to 0 silently.
- Data is never duplicated or dropped. Every accepted flit appears exactly once on the output, in acceptance order.

## Timing
- Reset values (while `i_reset` is high, and on the first edge after it deasserts):
  - `o_data_valid = 0`, `o_data = 0`, `o_grant = 0`, `ptr = 0`, `o_flit_count = 0`.
  - `o_data_ready = 0` for the whole time `i_reset` is high.
- Latency: a flit accepted at edge N is presented on `o_data`/`o_data_valid` after edge N.
- Throughput: one flit per cycle when `i_data_ready` is held high, including back-to-back flits from the same port or from different ports.
- Simultaneous events: output drain and new load in the same cycle are allowed (`load_en` is high because `i_data_ready` is high). The register is replaced with no bubble.
- Fairness: with all `NumIn` ports continuously valid, each port is granted exactly once in any `NumIn` consecutive input transfers.
- Pointer wrap: from `ptr = NumIn-1` the search continues at port 0.
- Reset mid-operation: any flit in the output register is discarded. No flit is accepted during the reset cycle.

## Test plan
- Port 2 only, 5 flits `0x10..0x14`, `i_data_ready = 1` → `o_data_ready = 0100` every cycle; outputs appear one cycle later, back-to-back; `o_grant = 2`; `o_flit_count = 5`.
- All 4 ports valid continuously, ready high → grant order 0,1,2,3,0,1,2,3; each output flit matches its source port; no idle cycles.
- Output holding a flit from port 1, `i_data_ready = 0` for 3 cycles, ports 0 and 3 valid:
  - `o_data_ready = 0000` and the output is stable throughout the stall.
  - When ready returns, port 3 wins (ptr = 2), then port 0.
- Ports 3 and 1 valid with `ptr = 3` → port 3 is granted, then `ptr` wraps to 0 and port 1 is granted next.
- `i_reset` pulsed for 1 cycle while 4 ports stream → next cycle `o_data_valid = 0`, `o_flit_count = 0`; the first grant after reset goes to port 0.
- Port 1 drops valid one cycle before its turn, with ports 0 and 2 valid and `ptr = 1` → port 2 is granted; port 1 receives no ready; no flit is lost or duplicated.
